// File: rtl/tpu_host_sequencer.sv
// -----------------------------------------------------------------------------
// tpu_host_sequencer
//
// On-chip host sequencer. It drives the TPU top-level control interface in
// place of a bench. One start pulse runs one complete pass:
//    weight memory -> FIFOs, FIFOs -> systolic array, input streaming (active),
//    then a wait for output write-back. This block is the initiator. The top
//    level responds through its *_done flags.
//
// Optional build macro: SEQ_TIMEOUT_EN
//    When defined, a watchdog limits the time spent in each wait state
//    (WWAIT, ARRLOAD, DRAIN) to TIMEOUT_CYCLES cycles. When it expires, the
//    watchdog aborts the pass and sets the sticky timeout_err_o flag.
//    When undefined, the wait states wait forever and timeout_err_o is 0.
//
// Ports
//    clk_i                    system clock, rising edge
//    reset_i                  asynchronous, active-high reset
//    start_i                  begin a pass (sampled only in IDLE)
//    weight_base_i            first weight-memory row of the pass
//    input_base_i             input-memory read base for the pass
//    output_base_i            output-memory write base for the pass
//    busy_o                   high in every state except IDLE
//    done_o                   one-cycle pulse when a pass completes
//    timeout_err_o            sticky watchdog error
//    weightMem_rd_en_o        per-lane weight read enable
//    weightMem_rd_addr_o      per-lane weight read address (all lanes equal)
//    mem_to_fifo_o            weight FIFO fill enable
//    mem_to_fifo_done_i       FIFO fill finished
//    fifo_to_arr_o            FIFO -> array shift enable
//    weight_write_o           per-column weight latch enable
//    fifo_to_arr_done_i       array weight load finished
//    inputMem_rd_addr_base_o  input base, replicated per lane
//    outputMem_wr_addr_base_o output base, replicated per lane
//    active_o                 multiply / input streaming enable
//    output_done_i            results written to output memory
//
// States
//    state     | meaning
//    ----------+------------------------------------------------------------
//    S_IDLE    | waiting for start_i
//    S_WLOAD   | WIDTH_HEIGHT cycles of weight-memory reads into the FIFOs
//    S_WWAIT   | wait for mem_to_fifo_done_i
//    S_ARRLOAD | shift FIFOs into the array until fifo_to_arr_done_i
//    S_ACT     | active_o held for ACTIVE_CYCLES cycles
//    S_DRAIN   | wait for output_done_i
//    S_DONE    | one-cycle done_o pulse
// -----------------------------------------------------------------------------
module tpu_host_sequencer #(
    parameter int WIDTH_HEIGHT   = 16,
    parameter int ACTIVE_CYCLES  = 19,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [7:0]                weight_base_i,
    input  logic [7:0]                input_base_i,
    input  logic [7:0]                output_base_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_err_o,
    output logic [WIDTH_HEIGHT-1:0]   weightMem_rd_en_o,
    output logic [WIDTH_HEIGHT*8-1:0] weightMem_rd_addr_o,
    output logic                      mem_to_fifo_o,
    input  logic                      mem_to_fifo_done_i,
    output logic                      fifo_to_arr_o,
    output logic [WIDTH_HEIGHT-1:0]   weight_write_o,
    input  logic                      fifo_to_arr_done_i,
    output logic [WIDTH_HEIGHT*8-1:0] inputMem_rd_addr_base_o,
    output logic [WIDTH_HEIGHT*8-1:0] outputMem_wr_addr_base_o,
    output logic                      active_o,
    input  logic                      output_done_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_WWAIT,
        S_ARRLOAD,
        S_ACT,
        S_DRAIN,
        S_DONE
    } state_t;

    // One down-counter serves both fixed-length phases (WLOAD and ACT).
    localparam int CNT_MAX = (WIDTH_HEIGHT > ACTIVE_CYCLES) ? WIDTH_HEIGHT : ACTIVE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         ibase_q, ibase_d;
    logic [7:0]         obase_q, obase_d;
    logic               rd_en_q, rd_en_d;
    logic               m2f_q, m2f_d;
    logic               f2a_q, f2a_d;
    logic               active_q, active_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               tmo_hit;

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic. Each output register gets the
    // value that belongs to the state being entered, so every output changes
    // on the same edge as the state.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        ibase_d  = ibase_q;
        obase_d  = obase_q;
        rd_en_d  = 1'b0;
        m2f_d    = 1'b0;
        f2a_d    = 1'b0;
        active_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_WLOAD;
                    cnt_d   = CNT_W'(WIDTH_HEIGHT - 1);
                    addr_d  = weight_base_i;
                    ibase_d = input_base_i;
                    obase_d = output_base_i;
                    rd_en_d = 1'b1;
                    m2f_d   = 1'b1;
                end
            end

            S_WLOAD: begin
                if (cnt_q == '0) begin
                    state_d = S_WWAIT;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    // 8-bit address wraps naturally mod 256.
                    addr_d  = addr_q + 8'd1;
                    rd_en_d = 1'b1;
                    m2f_d   = 1'b1;
                end
            end

            S_WWAIT: begin
                if (mem_to_fifo_done_i) begin
                    state_d = S_ARRLOAD;
                    f2a_d   = 1'b1;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end

            S_ARRLOAD: begin
                if (fifo_to_arr_done_i) begin
                    state_d  = S_ACT;
                    cnt_d    = CNT_W'(ACTIVE_CYCLES - 1);
                    active_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end else begin
                    f2a_d = 1'b1;
                end
            end

            S_ACT: begin
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    active_d = 1'b1;
                end
            end

            S_DRAIN: begin
                if (output_done_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            ibase_q  <= '0;
            obase_q  <= '0;
            rd_en_q  <= 1'b0;
            m2f_q    <= 1'b0;
            f2a_q    <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            ibase_q  <= ibase_d;
            obase_q  <= obase_d;
            rd_en_q  <= rd_en_d;
            m2f_q    <= m2f_d;
            f2a_q    <= f2a_d;
            active_q <= active_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // Watchdog. This counter counts down while the FSM stays in a wait state.
    // It reloads on every state change, so it starts fresh on each wait-state
    // entry. When a done flag and expiry land on the same edge, the done flag
    // wins.
    // -------------------------------------------------------------------------
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             terr_q, terr_d;
    logic             in_wait;

    assign in_wait = (state_q == S_WWAIT) || (state_q == S_ARRLOAD) || (state_q == S_DRAIN);
    assign tmo_hit = (tmo_q == '0);

    always_comb begin
        tmo_d  = tmo_q;
        terr_d = terr_q;
        if (state_d != state_q) begin
            tmo_d = TMO_W'(TIMEOUT_CYCLES - 1);
        end else if (in_wait) begin
            tmo_d = tmo_q - 1'b1;
        end
        // The only route from a wait state straight to IDLE is an expiry.
        if ((state_q == S_IDLE) && (state_d == S_WLOAD)) begin
            terr_d = 1'b0;
        end else if (in_wait && (state_d == S_IDLE)) begin
            terr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tmo_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err_o = terr_q;
`else
    assign tmo_hit = 1'b0;
    // The watchdog is compiled out, so the flag is a constant 0.
    // TIMEOUT_CYCLES is always positive, so this comparison is never true.
    assign timeout_err_o = (TIMEOUT_CYCLES < 0);
`endif

    assign busy_o                   = busy_q;
    assign done_o                   = done_q;
    assign weightMem_rd_en_o        = {WIDTH_HEIGHT{rd_en_q}};
    assign weightMem_rd_addr_o      = {WIDTH_HEIGHT{addr_q}};
    assign mem_to_fifo_o            = m2f_q;
    assign fifo_to_arr_o            = f2a_q;
    assign weight_write_o           = {WIDTH_HEIGHT{f2a_q}};
    assign inputMem_rd_addr_base_o  = {WIDTH_HEIGHT{ibase_q}};
    assign outputMem_wr_addr_base_o = {WIDTH_HEIGHT{obase_q}};
    assign active_o                 = active_q;

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for tpu_host_sequencer.
// A pass is modelled as a timeline of phases whose lengths follow from the
// responder delays. Each cycle's expected outputs are derived from that
// timeline and compared against the DUT at the falling edge.
// -----------------------------------------------------------------------------
module tb_tpu_host_sequencer;

    localparam int W   = 16;
    localparam int AC  = 19;
    localparam int TMO = 8;
`ifdef SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // phase codes used by the bench timeline
    localparam int P_IDLE = 0, P_WLOAD = 1, P_WWAIT = 2, P_ARR = 3, P_ACT = 4, P_DRAIN = 5, P_DONE = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [7:0]       wbase = '0, ibase = '0, obase = '0;
    logic             busy, done, terr, m2f, f2a, active;
    logic [W-1:0]     rd_en, wwrite;
    logic [W*8-1:0]   rd_addr, ib_bus, ob_bus;
    logic             m2f_done = 1'b0, f2a_done = 1'b0, out_done = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_ib = '0, exp_ob = '0;
    logic       exp_terr = 1'b0;

    always #5 clk = ~clk;

    tpu_host_sequencer #(
        .WIDTH_HEIGHT  (W),
        .ACTIVE_CYCLES (AC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i                   (clk),
        .reset_i                 (reset),
        .start_i                 (start),
        .weight_base_i           (wbase),
        .input_base_i            (ibase),
        .output_base_i           (obase),
        .busy_o                  (busy),
        .done_o                  (done),
        .timeout_err_o           (terr),
        .weightMem_rd_en_o       (rd_en),
        .weightMem_rd_addr_o     (rd_addr),
        .mem_to_fifo_o           (m2f),
        .mem_to_fifo_done_i      (m2f_done),
        .fifo_to_arr_o           (f2a),
        .weight_write_o          (wwrite),
        .fifo_to_arr_done_i      (f2a_done),
        .inputMem_rd_addr_base_o (ib_bus),
        .outputMem_wr_addr_base_o(ob_bus),
        .active_o                (active),
        .output_done_i           (out_done)
    );

    // Flag level for cycle c. The window opens at cycle t and the responder
    // answers d cycles later. Inside the window the flag is low until the
    // answer. Outside the window it is irrelevant and may be noise.
    function automatic logic flag_at(int c, int t, int d, bit noise);
        if (t >= 0 && c == t + d) return 1'b1;
        if (t >= 0 && c >= t && c < t + d) return 1'b0;
        return noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // Runs one pass starting in IDLE at the current (mid-cycle) time.
    // If abort_at >= 0, reset is asserted in that cycle and the task returns
    // with reset held high.
    task automatic run_pass(input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob,
                            input int d1, input int d2, input int d3, input bit noise,
                            input int abort_at);
        int          ph[$];
        int          t_ww, t_al, t_dr, n;
        bit          to_any;
        logic [37:0] got_c, exp_c;
        logic [7:0]  a;
        int          p;
        t_ww = -1; t_al = -1; t_dr = -1; to_any = 1'b0;
        for (int i = 0; i < W; i++) ph.push_back(P_WLOAD);
        t_ww = ph.size();
        if (TO_EN && d1 >= TMO) begin n = TMO; to_any = 1'b1; end else n = d1 + 1;
        for (int i = 0; i < n; i++) ph.push_back(P_WWAIT);
        if (!to_any) begin
            t_al = ph.size();
            if (TO_EN && d2 >= TMO) begin n = TMO; to_any = 1'b1; end else n = d2 + 1;
            for (int i = 0; i < n; i++) ph.push_back(P_ARR);
            if (!to_any) begin
                for (int i = 0; i < AC; i++) ph.push_back(P_ACT);
                t_dr = ph.size();
                if (TO_EN && d3 >= TMO) begin n = TMO; to_any = 1'b1; end else n = d3 + 1;
                for (int i = 0; i < n; i++) ph.push_back(P_DRAIN);
                if (!to_any) ph.push_back(P_DONE);
            end
        end
        ph.push_back(P_IDLE);

        wbase = wb; ibase = ib; obase = ob; start = 1'b1;
        @(posedge clk);
        exp_ib = ib; exp_ob = ob; exp_terr = 1'b0;
        for (int c = 0; c < ph.size(); c++) begin
            #1;
            p = ph[c];
            if (p == P_IDLE) begin
                start = 1'b0; m2f_done = 1'b0; f2a_done = 1'b0; out_done = 1'b0;
            end else begin
                start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                wbase    = 8'($urandom); ibase = 8'($urandom); obase = 8'($urandom);
                m2f_done = flag_at(c, t_ww, d1, noise);
                f2a_done = flag_at(c, t_al, d2, noise);
                out_done = flag_at(c, t_dr, d3, noise);
            end
            @(negedge clk);
            if (p == P_IDLE) exp_terr = to_any;
            exp_c = {p != P_IDLE, p == P_DONE, exp_terr, p == P_WLOAD, p == P_ARR, p == P_ACT,
                     {W{p == P_WLOAD}}, {W{p == P_ARR}}};
            got_c = {busy, done, terr, m2f, f2a, active, rd_en, wwrite};
            vectors++;
            if (got_c !== exp_c) begin
                miscompares++;
                $display("FAIL ctrl cycle=%0d phase=%0d got=%h exp=%h", c, p, got_c, exp_c);
            end
            vectors++;
            if (ib_bus !== {W{exp_ib}} || ob_bus !== {W{exp_ob}}) begin
                miscompares++;
                $display("FAIL bases cycle=%0d got_in=%h got_out=%h exp_in=%h exp_out=%h",
                         c, ib_bus[7:0], ob_bus[7:0], exp_ib, exp_ob);
            end
            if (p == P_WLOAD) begin
                a = wb + 8'(c);
                vectors++;
                if (rd_addr !== {W{a}}) begin
                    miscompares++;
                    $display("FAIL rd_addr cycle=%0d got=%h exp=%h", c, rd_addr, {W{a}});
                end
            end
            if (c == abort_at) begin
                #2 reset = 1'b1;
                #1;
                exp_ib = '0; exp_ob = '0; exp_terr = 1'b0;
                vectors++;
                if ({busy, done, terr, m2f, f2a, active, rd_en, wwrite} !== 38'd0 ||
                    rd_addr !== '0 || ib_bus !== '0 || ob_bus !== '0) begin
                    miscompares++;
                    $display("FAIL async_reset cycle=%0d active=%b busy=%b", c, active, busy);
                end
                return;
            end
            if (c < ph.size() - 1) @(posedge clk);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = ~start;
            vectors++;
            if ({busy, done, terr, m2f, f2a, active, rd_en, wwrite, rd_addr, ib_bus, ob_bus} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs busy=%b active=%b rd_en=%h", busy, active, rd_en);
            end
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || m2f !== 1'b0 || active !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle busy=%b m2f=%b active=%b done=%b", busy, m2f, active, done);
            end
        end
    endtask

    task automatic test_nominal();
        run_pass(8'h00, 8'h35, 8'h5A, 16, 16, 40, 1'b0, -1);
    endtask

    task automatic test_second_pass();
        run_pass(8'h20, 8'h20, 8'h20, 16, 16, 40, 1'b0, -1);
    endtask

    task automatic test_wrap_and_ignored_start();
        run_pass(8'hF8, 8'h11, 8'h22, 3, 2, 5, 1'b1, -1);
    endtask

    task automatic test_immediate_done();
        // Every done flag is already high on wait-state entry, so each wait
        // state lasts a single cycle.
        run_pass(8'h7C, 8'h01, 8'hFE, 0, 0, 0, 1'b1, -1);
    endtask

    task automatic test_reset_mid_act();
        run_pass(8'h40, 8'h44, 8'h48, 2, 2, 4, 1'b0, W + 3 + 3 + 5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || active !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold busy=%b active=%b", busy, active);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rd_en !== '0) begin
            miscompares++;
            $display("FAIL post_reset_idle busy=%b rd_en=%h", busy, rd_en);
        end
        run_pass(8'h90, 8'h12, 8'h34, 1, 4, 2, 1'b1, -1);
    endtask

    task automatic test_timeout();
        // output_done never answers within the window (a timeout when the
        // watchdog is built in, a long wait otherwise). The next pass must
        // clear the error flag on its first cycle.
        run_pass(8'h33, 8'h44, 8'h55, 1, 1, 60, 1'b0, -1);
        run_pass(8'hA0, 8'hB0, 8'hC0, 2, 3, 1, 1'b0, -1);
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 8; i++) begin
            run_pass(8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12),
                     1'b1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_second_pass();
        test_wrap_and_ignored_start();
        test_immediate_done();
        test_reset_mid_act();
        test_timeout();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
